mybus_sequencer: RTL and testbench

MYBUS_SEQUENCER -- requirements
Module: mybus_sequencer

---
 rtl/mybus_sequencer_if.sv | 27 ++
 rtl/mybus_sequencer.sv | 149 ++++++++++++++
 tb/tb_mybus_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mybus_sequencer_if.sv
// Bus bundle between the requester/Stage1/Stage5-7 side and the sequencer.
// master = the sequencer itself, slave = the environment driving it.
interface mybus_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic [DATA_W-1:0] req_data;
  logic              req_ready;
  logic              start;
  logic              data;
  logic              ready;
  logic              dataReady;
  logic              execute;
  logic              dataTx;
  logic              done;
  logic              timeout_err;

  modport master (
    input  req_valid, req_data, ready, dataReady,
    output req_ready, start, data, execute, dataTx, done, timeout_err
  );

  modport slave (
    output req_valid, req_data, ready, dataReady,
    input  req_ready, start, data, execute, dataTx, done, timeout_err
  );
endinterface

// File: rtl/mybus_sequencer.sv
// Single-word sequencer: shift a word into Stage1, wait for its handshake,
// strobe execute, then shift the same word out on dataTx.
//
// state | meaning
// IDLE  | req_ready high, waiting for a requester word
// SHIFT | DATA_W cycles serialising the word on data, start in first cycle
// WAIT  | waiting for ready & dataReady, bounded by TIMEOUT cycles
// EXEC  | one cycle with execute high
// TX    | DATA_W cycles serialising the word on dataTx, done in last cycle
module mybus_sequencer #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mybus_sequencer_if.master    bus
);

  localparam int              BCW       = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0]  LAST_BIT  = BCW'(DATA_W - 1);
  localparam logic [7:0]      WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    WAIT  = 3'd2,
    EXEC  = 3'd3,
    TX    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]   sreg_q, sreg_d;
  logic [DATA_W-1:0]   sreg_rot;

  logic req_ready_q, req_ready_d;
  logic start_q, start_d;
  logic data_q, data_d;
  logic execute_q, execute_d;
  logic data_tx_q, data_tx_d;
  logic done_q, done_d;
  logic timeout_err_q, timeout_err_d;

  // Rotating rather than shifting leaves the word intact after SHIFT for reuse in TX.
  assign sreg_rot = {sreg_q[DATA_W-2:0], sreg_q[DATA_W-1]};

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    sreg_d        = sreg_q;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          sreg_d    = bus.req_data;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = sreg_rot;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d  = '0;
          wait_cnt_d = '0;
          state_d    = WAIT;
        end else begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      WAIT: begin
        // The pair wins over the timeout when both happen in the same cycle.
        if (bus.ready && bus.dataReady) begin
          wait_cnt_d = '0;
          state_d    = EXEC;
        end else if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d    = '0;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      EXEC: begin
        bit_cnt_d = '0;
        state_d   = TX;
      end
      TX: begin
        sreg_d = sreg_rot;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the flops present them in that state's cycle.
    req_ready_d = (state_d == IDLE);
    start_d     = (state_q == IDLE) && (state_d == SHIFT);
    data_d      = (state_d == SHIFT) && sreg_d[DATA_W-1];
    execute_d   = (state_d == EXEC);
    data_tx_d   = (state_d == TX) && sreg_d[DATA_W-1];
    done_d      = (state_d == TX) && (bit_cnt_d == LAST_BIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      sreg_q        <= '0;
      req_ready_q   <= 1'b1;
      start_q       <= 1'b0;
      data_q        <= 1'b0;
      execute_q     <= 1'b0;
      data_tx_q     <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      sreg_q        <= sreg_d;
      req_ready_q   <= req_ready_d;
      start_q       <= start_d;
      data_q        <= data_d;
      execute_q     <= execute_d;
      data_tx_q     <= data_tx_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.start       = start_q;
  assign bus.data        = data_q;
  assign bus.execute     = execute_q;
  assign bus.dataTx      = data_tx_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mybus_sequencer.sv
// Self-checking bench for mybus_sequencer: directed table, reset abort and
// randomised sequences compared cycle by cycle against a timeline model.
module tb_mybus_sequencer;

  localparam int W = 8;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mybus_sequencer_if #(.DATA_W(W)) bus ();

  mybus_sequencer #(.DATA_W(W), .TIMEOUT(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  bit rdy_pat  [1:255];
  bit drdy_pat [1:255];

  // {req_ready, start, data, execute, dataTx, done, timeout_err}
  logic [6:0] obs;
  assign obs = {bus.req_ready, bus.start, bus.data, bus.execute,
                bus.dataTx, bus.done, bus.timeout_err};

  localparam logic [6:0] RESET_VEC = 7'b1000000;

  typedef struct {
    logic [7:0] word;
    int         r_from;
    int         d_from;
    bit         hold;
    int         exp_exec;
    int         exp_done;
    int         exp_to;
    string      name;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected outputs in cycle c after the acceptance edge, given the first WAIT
  // cycle k in which both handshake inputs are high (0 = never within T).
  function automatic logic [6:0] exp_vec(input int c, input int k, input logic [7:0] w);
    logic [6:0] v;
    v = '0;
    if (c >= 1 && c <= W) begin
      v[5] = (c == 1);
      v[4] = w[W-c];
    end else if (k > 0) begin
      if (c == W + k + 1) begin
        v[3] = 1'b1;
      end else if (c >= W + k + 2 && c <= 2*W + k + 1) begin
        v[2] = w[W - 1 - (c - (W + k + 2))];
        v[1] = (c == 2*W + k + 1);
      end else if (c >= 2*W + k + 2) begin
        v[6] = 1'b1;
      end
    end else begin
      if (c == W + T + 1) begin
        v[6] = 1'b1;
        v[0] = 1'b1;
      end else if (c > W + T + 1) begin
        v[6] = 1'b1;
      end
    end
    return v;
  endfunction

  task automatic set_pat(input int rf, input int df);
    for (int j = 1; j <= 255; j++) begin
      rdy_pat[j]  = (rf != 0) && (j >= rf);
      drdy_pat[j] = (df != 0) && (j >= df);
    end
  endtask

  // Called inside a cycle where the DUT is idle; offers w, then checks every
  // cycle up to and including the first idle cycle after the sequence.
  task automatic run_seq(input logic [7:0] w, input bit hold, input int abort_c,
                         output int ex_c, output int dn_c, output int to_c);
    int k;
    int n;
    k = 0;
    for (int j = 1; j <= T; j++)
      if (k == 0 && rdy_pat[j] && drdy_pat[j]) k = j;
    n = (k > 0) ? 2*W + k + 2 : W + T + 1;
    ex_c = 0;
    dn_c = 0;
    to_c = 0;
    bus.req_valid = 1'b1;
    bus.req_data  = w;
    check("accept_ready", 32'(bus.req_ready), 32'd1);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      bus.req_valid = hold;
      bus.req_data  = 8'($urandom);
      if (c > W && c <= W + T) begin
        bus.ready     = rdy_pat[c-W];
        bus.dataReady = drdy_pat[c-W];
      end else begin
        bus.ready     = 1'($urandom);
        bus.dataReady = 1'($urandom);
      end
      if (c == abort_c) begin
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'(obs), 32'(RESET_VEC));
        @(negedge clk);
        check("rst_low", 32'(obs), 32'(RESET_VEC));
        @(posedge clk);
        #1;
        check("rst_edge", 32'(obs), 32'(RESET_VEC));
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      check($sformatf("cycle%0d_w%02h_k%0d", c, w, k), 32'(obs), 32'(exp_vec(c, k, w)));
      if (obs[3] && ex_c == 0) ex_c = c;
      if (obs[1] && dn_c == 0) dn_c = c;
      if (obs[0] && to_c == 0) to_c = c;
    end
  endtask

  initial begin
    int ex, dn, to;
    logic [7:0] w;
    bit hold;

    tbl[0] = '{8'hA5, 1,  1,  1'b0, 10, 18, 0,  "nominal"};
    tbl[1] = '{8'h5A, 3,  5,  1'b0, 14, 22, 0,  "late_pair"};
    tbl[2] = '{8'hF0, 1,  0,  1'b0, 0,  0,  25, "timeout_ready_only"};
    tbl[3] = '{8'h0F, 0,  1,  1'b0, 0,  0,  25, "timeout_drdy_only"};
    tbl[4] = '{8'h81, 16, 16, 1'b0, 25, 33, 0,  "boundary"};
    tbl[5] = '{8'h3C, 1,  1,  1'b1, 10, 18, 0,  "b2b_first"};
    tbl[6] = '{8'hC3, 1,  1,  1'b0, 10, 18, 0,  "b2b_second"};

    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    bus.ready     = 1'b0;
    bus.dataReady = 1'b0;

    #12;
    check("reset_state", 32'(obs), 32'(RESET_VEC));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      set_pat(tbl[i].r_from, tbl[i].d_from);
      run_seq(tbl[i].word, tbl[i].hold, 0, ex, dn, to);
      check({tbl[i].name, "_exec"},    32'(ex), 32'(tbl[i].exp_exec));
      check({tbl[i].name, "_done"},    32'(dn), 32'(tbl[i].exp_done));
      check({tbl[i].name, "_timeout"}, 32'(to), 32'(tbl[i].exp_to));
    end

    // Reset during the fourth TX cycle, then a clean sequence.
    set_pat(1, 1);
    run_seq(8'h96, 1'b0, 14, ex, dn, to);
    check("abort_no_done", 32'(dn), 32'd0);
    run_seq(8'h69, 1'b0, 0, ex, dn, to);
    check("after_reset_exec", 32'(ex), 32'd10);
    check("after_reset_done", 32'(dn), 32'd18);

    for (int r = 0; r < 30; r++) begin
      w    = 8'($urandom);
      hold = 1'($urandom);
      for (int j = 1; j <= 255; j++) begin
        rdy_pat[j]  = 1'($urandom);
        drdy_pat[j] = ($urandom_range(0, 3) == 0);
      end
      run_seq(w, hold, 0, ex, dn, to);
      check("rand_exclusive", 32'(dn != 0 && to != 0), 32'd0);
    end

    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
